external_memory_arbiter: RTL

Parametrised successor to the single-master serial memory path: arbitrates NUM_MASTERS external agents (serial command processor, debug port, DMA loader) onto the processor's external memory port. Before driving the memory it asserts pause to the processor clock enabler and waits a settle interval. It then runs one access with a per-master read/write mode and returns read data with a done pulse. Sits between the external agents and Processor's externalMemoryControl/externalAddress/externalData/externalReadMode/externalWriteMode/externalDataOut lines.

---
 rtl/external_memory_arbiter_pkg.sv | 35 +++
 rtl/external_memory_arbiter_picker.sv | 36 +++
 rtl/external_memory_arbiter.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/external_memory_arbiter_pkg.sv
//------------------------------------------------------------------------------
// Module   : MemoryModesPackage
// Brief    : Shared memory access modes and external arbiter state encoding.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package MemoryModesPackage;

   typedef enum logic [2:0] {
      ReadWriteMode_NONE = 3'd0,
      ReadWriteMode_BYTE = 3'd1,
      ReadWriteMode_HALF = 3'd2,
      ReadWriteMode_WORD = 3'd3
   } ReadWriteModes;

   typedef enum logic [2:0] {
      ExtArb_IDLE    = 3'd0,
      ExtArb_SETTLE  = 3'd1,
      ExtArb_ACCESS  = 3'd2,
      ExtArb_DONE    = 3'd3,
      ExtArb_RELEASE = 3'd4,
      ExtArb_LOCKED  = 3'd5
   } ExtArbState;

   localparam int c_COUNT_WIDTH = 4;

   // Index width for a requester vector; a single requester still needs one bit.
   function automatic int ptr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/external_memory_arbiter_picker.sv
//------------------------------------------------------------------------------
// Module   : round_robin_picker
// Brief    : Combinational round-robin search: first set request at or after
//            the pointer, wrapping, as a one-hot winner plus a valid flag.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module round_robin_picker #(
   parameter int NUM_MASTERS = 2,
   parameter int PTR_WIDTH   = 1
) (
   input  logic [NUM_MASTERS-1:0] req,
   input  logic [PTR_WIDTH-1:0]   pointer,
   output logic [NUM_MASTERS-1:0] winner,
   output logic                   valid
);

   logic [PTR_WIDTH-1:0] w_idx;

   always_comb begin
      winner = '0;
      valid  = 1'b0;
      w_idx  = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         w_idx = PTR_WIDTH'((int'(pointer) + i) % NUM_MASTERS);
         if (!valid && req[w_idx]) begin
            winner[w_idx] = 1'b1;
            valid         = 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/external_memory_arbiter.sv
//------------------------------------------------------------------------------
// Module   : external_memory_arbiter
// Brief    : Round-robin arbiter of external agents onto the processor's
//            external memory port, pausing the processor around each access.
//            Optional grant locking is enabled by defining EXT_MEM_ARB_LOCK_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module external_memory_arbiter
   import MemoryModesPackage::*;
#(
   parameter int NUM_MASTERS  = 2,
   parameter int ADDR_WIDTH   = 32,
   parameter int DATA_WIDTH   = 32,
   parameter int PAUSE_SETTLE = 2,
   parameter int MEM_LATENCY  = 1
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [NUM_MASTERS-1:0]           req,
   input  logic [NUM_MASTERS-1:0]           write,
   input  logic [3*NUM_MASTERS-1:0]         mode,
   input  logic [NUM_MASTERS-1:0]           lock,
   input  logic [ADDR_WIDTH*NUM_MASTERS-1:0] addr,
   input  logic [DATA_WIDTH*NUM_MASTERS-1:0] wdata,
   output logic [NUM_MASTERS-1:0]           gnt,
   output logic [NUM_MASTERS-1:0]           done,
   output logic [DATA_WIDTH-1:0]            rdata,
   output logic                             pause,
   output logic                             ext_control,
   output logic [ADDR_WIDTH-1:0]            ext_address,
   output logic [DATA_WIDTH-1:0]            ext_data,
   output logic [2:0]                       ext_read_mode,
   output logic [2:0]                       ext_write_mode,
   input  logic [DATA_WIDTH-1:0]            ext_data_out
);

   localparam int c_PTR_W = ptr_width(NUM_MASTERS);
   localparam logic [c_COUNT_WIDTH-1:0] c_SETTLE_LOAD =
      c_COUNT_WIDTH'((PAUSE_SETTLE > 0) ? PAUSE_SETTLE - 1 : 0);
   localparam logic [c_COUNT_WIDTH-1:0] c_ACCESS_LOAD =
      c_COUNT_WIDTH'((MEM_LATENCY > 0) ? MEM_LATENCY - 1 : 0);

   ExtArbState                r_state, w_state_next;
   logic [NUM_MASTERS-1:0]    r_gnt, w_gnt_next;
   logic [NUM_MASTERS-1:0]    r_done, w_done_next;
   logic [c_PTR_W-1:0]        r_gnt_idx, w_gnt_idx_next;
   logic [c_PTR_W-1:0]        r_ptr, w_ptr_next;
   logic [c_COUNT_WIDTH-1:0]  r_count, w_count_next;
   logic [DATA_WIDTH-1:0]     r_rdata, w_rdata_next;
   logic                      r_pause, w_pause_next;
   logic                      r_ext_control, w_ext_control_next;
   logic [ADDR_WIDTH-1:0]     r_ext_address, w_ext_address_next;
   logic [DATA_WIDTH-1:0]     r_ext_data, w_ext_data_next;
   logic [2:0]                r_read_mode, w_read_mode_next;
   logic [2:0]                r_write_mode, w_write_mode_next;
   logic                      w_enter_access;

   logic [NUM_MASTERS-1:0]    w_pick_req, w_win;
   logic                      w_win_valid;
   logic [c_PTR_W-1:0]        w_win_idx, w_target_idx;
   logic [ADDR_WIDTH-1:0]     w_sel_addr;
   logic [DATA_WIDTH-1:0]     w_sel_wdata;
   logic [2:0]                w_sel_mode;
   logic                      w_sel_write;

`ifdef EXT_MEM_ARB_LOCK_EN
   logic                      r_lock_first, w_lock_first_next;
`else
   logic                      w_unused_lock;
   assign w_unused_lock = ^lock;
`endif

   // The master just served may still hold req during RELEASE; hide it there.
   assign w_pick_req = req & ~((r_state == ExtArb_RELEASE) ? r_gnt : '0);

   round_robin_picker #(
      .NUM_MASTERS (NUM_MASTERS),
      .PTR_WIDTH   (c_PTR_W)
   ) u_picker (
      .req     (w_pick_req),
      .pointer (r_ptr),
      .winner  (w_win),
      .valid   (w_win_valid)
   );

   always_comb begin
      w_win_idx = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (w_win[i]) w_win_idx = c_PTR_W'(i);
      end
   end

   // Master whose request fields feed the next access (fresh winner or current grantee).
   assign w_target_idx = ((r_state == ExtArb_IDLE) || (r_state == ExtArb_RELEASE)) ?
                         w_win_idx : r_gnt_idx;

   always_comb begin
      w_sel_addr  = '0;
      w_sel_wdata = '0;
      w_sel_mode  = '0;
      w_sel_write = 1'b0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (w_target_idx == c_PTR_W'(i)) begin
            w_sel_addr  = addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            w_sel_wdata = wdata[i*DATA_WIDTH +: DATA_WIDTH];
            w_sel_mode  = mode[i*3 +: 3];
            w_sel_write = write[i];
         end
      end
   end

   always_comb begin
      w_state_next       = r_state;
      w_gnt_next         = r_gnt;
      w_gnt_idx_next     = r_gnt_idx;
      w_ptr_next         = r_ptr;
      w_count_next       = r_count;
      w_done_next        = '0;
      w_rdata_next       = r_rdata;
      w_pause_next       = r_pause;
      w_ext_control_next = r_ext_control;
      w_ext_address_next = r_ext_address;
      w_ext_data_next    = r_ext_data;
      w_read_mode_next   = r_read_mode;
      w_write_mode_next  = r_write_mode;
      w_enter_access     = 1'b0;
`ifdef EXT_MEM_ARB_LOCK_EN
      w_lock_first_next  = 1'b0;
`endif

      case (r_state)
         ExtArb_IDLE: begin
            if (w_win_valid) begin
               w_gnt_next     = w_win;
               w_gnt_idx_next = w_win_idx;
               w_pause_next   = 1'b1;
               if (PAUSE_SETTLE == 0) begin
                  w_enter_access = 1'b1;
               end else begin
                  w_state_next = ExtArb_SETTLE;
                  w_count_next = c_SETTLE_LOAD;
               end
            end
         end
         ExtArb_SETTLE: begin
            if (r_count == '0) w_enter_access = 1'b1;
            else               w_count_next   = r_count - 1'b1;
         end
         ExtArb_ACCESS: begin
            if (r_count == '0) begin
               w_state_next       = ExtArb_DONE;
               w_done_next        = r_gnt;
               w_ext_control_next = 1'b0;
               w_read_mode_next   = ReadWriteMode_NONE;
               w_write_mode_next  = ReadWriteMode_NONE;
               w_ptr_next         = (r_gnt_idx == c_PTR_W'(NUM_MASTERS - 1)) ?
                                    '0 : r_gnt_idx + 1'b1;
               if (!w_sel_write) w_rdata_next = ext_data_out;
            end else begin
               w_count_next = r_count - 1'b1;
            end
         end
         ExtArb_DONE: begin
`ifdef EXT_MEM_ARB_LOCK_EN
            if (lock[r_gnt_idx]) begin
               w_state_next      = ExtArb_LOCKED;
               w_lock_first_next = 1'b1;
            end else begin
               w_state_next = ExtArb_RELEASE;
            end
`else
            w_state_next = ExtArb_RELEASE;
`endif
         end
         ExtArb_RELEASE: begin
            if (w_win_valid) begin
               w_gnt_next     = w_win;
               w_gnt_idx_next = w_win_idx;
               w_enter_access = 1'b1;
            end else begin
               w_state_next = ExtArb_IDLE;
               w_pause_next = 1'b0;
               w_gnt_next   = '0;
            end
         end
`ifdef EXT_MEM_ARB_LOCK_EN
         // First LOCKED cycle ignores the grantee's req, which may still be the old one.
         ExtArb_LOCKED: begin
            if (!r_lock_first) begin
               if (req[r_gnt_idx])        w_enter_access = 1'b1;
               else if (!lock[r_gnt_idx]) w_state_next   = ExtArb_RELEASE;
            end
         end
`endif
         default: begin
            w_state_next = ExtArb_IDLE;
         end
      endcase

      if (w_enter_access) begin
         w_state_next       = ExtArb_ACCESS;
         w_count_next       = c_ACCESS_LOAD;
         w_ext_control_next = 1'b1;
         w_ext_address_next = w_sel_addr;
         w_ext_data_next    = w_sel_wdata;
         if (w_sel_write) begin
            w_write_mode_next = w_sel_mode;
            w_read_mode_next  = ReadWriteMode_NONE;
         end else begin
            w_write_mode_next = ReadWriteMode_NONE;
            w_read_mode_next  = w_sel_mode;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= ExtArb_IDLE;
         r_gnt         <= '0;
         r_gnt_idx     <= '0;
         r_ptr         <= '0;
         r_count       <= '0;
         r_done        <= '0;
         r_rdata       <= '0;
         r_pause       <= 1'b0;
         r_ext_control <= 1'b0;
         r_ext_address <= '0;
         r_ext_data    <= '0;
         r_read_mode   <= ReadWriteMode_NONE;
         r_write_mode  <= ReadWriteMode_NONE;
      end else begin
         r_state       <= w_state_next;
         r_gnt         <= w_gnt_next;
         r_gnt_idx     <= w_gnt_idx_next;
         r_ptr         <= w_ptr_next;
         r_count       <= w_count_next;
         r_done        <= w_done_next;
         r_rdata       <= w_rdata_next;
         r_pause       <= w_pause_next;
         r_ext_control <= w_ext_control_next;
         r_ext_address <= w_ext_address_next;
         r_ext_data    <= w_ext_data_next;
         r_read_mode   <= w_read_mode_next;
         r_write_mode  <= w_write_mode_next;
      end
   end

`ifdef EXT_MEM_ARB_LOCK_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_lock_first <= 1'b0;
      else     r_lock_first <= w_lock_first_next;
   end
`endif

   assign gnt            = r_gnt;
   assign done           = r_done;
   assign rdata          = r_rdata;
   assign pause          = r_pause;
   assign ext_control    = r_ext_control;
   assign ext_address    = r_ext_address;
   assign ext_data       = r_ext_data;
   assign ext_read_mode  = r_read_mode;
   assign ext_write_mode = r_write_mode;

endmodule

`default_nettype wire
